// File: rtl/conv33_window_gen_pkg.sv
// Shared definitions for the conv33 window generator: FSM state encoding and
// default frame geometry.
package conv33_window_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_W      = 28;
  localparam int DEF_IMG_H      = 28;

endpackage

// File: rtl/conv33_window_gen_line_buffer.sv
// One-row line buffer: single-port RAM with asynchronous read, so a read and a
// write at the same address in one cycle return the old row (read-before-write).
module conv33_line_buffer
  import conv33_window_gen_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_IMG_W,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Row storage is data only; stale contents are masked by the frame counters.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/conv33_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream. Emits every
// unpadded stride-1 window of an IMG_H x IMG_W frame on a valid/ready port.
// Optional build macro CONV33_WIN_STALL_CNT_EN adds a 32-bit saturating
// backpressure cycle counter on port stall_cnt.
module conv33_window_gen
  import conv33_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] out_0_0,
  output logic [DATA_WIDTH-1:0] out_0_1,
  output logic [DATA_WIDTH-1:0] out_0_2,
  output logic [DATA_WIDTH-1:0] out_1_0,
  output logic [DATA_WIDTH-1:0] out_1_1,
  output logic [DATA_WIDTH-1:0] out_1_2,
  output logic [DATA_WIDTH-1:0] out_2_0,
  output logic [DATA_WIDTH-1:0] out_2_1,
  output logic [DATA_WIDTH-1:0] out_2_2
`ifdef CONV33_WIN_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic                  accept;
  logic                  last_pix;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] lb0_out, lb1_out;
  logic [DATA_WIDTH-1:0] win_p1 [3][3];
  logic                  vld_p1;

  assign ready_out = (state_q == RUN) && (!vld_p1 || ready_in);
  assign accept    = valid_in && ready_out;
  assign last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign done      = done_q;
  assign valid_out = vld_p1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: run until the frame's last pixel, then drain the last window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_pix) state_d = FLUSH;
      FLUSH:   if (!vld_p1 || ready_in) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame position counters: cleared on frame start, advance on every accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (state_q == IDLE && start) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Registered done pulse, one cycle after the FSM passes through DONE.
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= (state_q == DONE);
  end

  // ---- stage p0: line buffers, chained so lb1 holds the row two above ----
  conv33_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb0 (
    .clk     (clk),
    .we      (accept),
    .addr    (col_q),
    .wr_data (pix_in),
    .rd_data (lb0_out)
  );

  conv33_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .clk     (clk),
    .we      (accept),
    .addr    (col_q),
    .wr_data (lb0_out),
    .rd_data (lb1_out)
  );

  // ---- stage p1: 3x3 window shift register and its valid flag ----
  // Window shifts left on accept; valid only when a full unwrapped 3x3 is present.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_p1[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_p1[r][0] <= win_p1[r][1];
        win_p1[r][1] <= win_p1[r][2];
      end
      win_p1[0][2] <= lb1_out;
      win_p1[1][2] <= lb0_out;
      win_p1[2][2] <= pix_in;
      vld_p1       <= (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    end else if (vld_p1 && ready_in) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_0_0 = win_p1[0][0];
  assign out_0_1 = win_p1[0][1];
  assign out_0_2 = win_p1[0][2];
  assign out_1_0 = win_p1[1][0];
  assign out_1_1 = win_p1[1][1];
  assign out_1_2 = win_p1[1][2];
  assign out_2_0 = win_p1[2][0];
  assign out_2_1 = win_p1[2][1];
  assign out_2_2 = win_p1[2][2];

`ifdef CONV33_WIN_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Backpressure cycle counter: cleared at frame start, held after the frame ends.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (state_q == IDLE && start)
      stall_cnt <= '0;
    else if ((state_q == RUN || state_q == FLUSH) && vld_p1 && !ready_in)
      stall_cnt <= sat_inc(stall_cnt);
  end
`endif

endmodule

// File: tb/tb_conv33_window_gen.sv
// Scoreboard bench for conv33_window_gen on a 4x4 frame.
module tb_conv33_window_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       done;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic [7:0] pix_in = '0;
  logic       valid_out;
  logic       ready_in = 1'b1;
  logic [7:0] o00, o01, o02, o10, o11, o12, o20, o21, o22;
`ifdef CONV33_WIN_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  conv33_window_gen #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .pix_in    (pix_in),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .out_0_0   (o00),
    .out_0_1   (o01),
    .out_0_2   (o02),
    .out_1_0   (o10),
    .out_1_1   (o11),
    .out_1_2   (o12),
    .out_2_0   (o20),
    .out_2_1   (o21),
    .out_2_2   (o22)
`ifdef CONV33_WIN_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_hs_cyc = 0;
  logic [71:0] sb [$];
  logic [71:0] win_now;

  assign win_now = {o00, o01, o02, o10, o11, o12, o20, o21, o22};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [71:0] got, logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endfunction

  // Window whose top-left pixel is at (r0,c0) in a 4x4 frame of base+index.
  function automatic logic [71:0] exp_win(int base, int r0, int c0);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(8 - (i*3 + j))*8 +: 8] = 8'(base + (r0 + i)*4 + c0 + j);
    return w;
  endfunction

  // Monitor: compare every handshaken window and the done latency.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out && ready_in) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_window got=%h", win_now);
        end else begin
          chk("window", win_now, sb.pop_front());
        end
        last_hs_cyc = cyc;
      end
      if (done) chk("done_latency", 72'(cyc - last_hs_cyc), 72'd2);
    end
  end

  task automatic push_pixel(input logic [7:0] p);
    logic acc;
    int   n;
    valid_in = 1'b1;
    pix_in   = p;
    n        = 0;
    acc      = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ready_out;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 72'd0, 72'd1);
    valid_in = 1'b0;
  endtask

  task automatic wait_done();
    int  n;
    bit  seen;
    n    = 0;
    seen = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    if (!seen) chk("done_timeout", 72'd0, 72'd1);
    @(posedge clk);
    #1;
    chk("queue_empty", 72'(sb.size()), 72'd0);
  endtask

  // mode 0: plain, 1: 5-cycle stall on window 1, 2: valid toggling, 3: start during RUN
  task automatic run_frame(input int base, input int mode);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef CONV33_WIN_STALL_CNT_EN
    chk("stall_cnt_cleared", 72'(stall_cnt), 72'd0);
`endif
    for (int r0 = 0; r0 < 2; r0++)
      for (int c0 = 0; c0 < 2; c0++)
        sb.push_back(exp_win(base, r0, c0));
    for (int i = 0; i < 16; i++) begin
      if (mode == 3 && i == 5) start = 1'b1;
      push_pixel(8'(base + i));
      start = 1'b0;
      if (mode == 2) begin
        @(posedge clk);
        #1;
      end
      if (mode == 1 && i == 10) begin
        ready_in = 1'b0;
        valid_in = 1'b1;
        pix_in   = 8'(base + 11);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_valid", 72'(valid_out), 72'd1);
          chk("stall_ready_out", 72'(ready_out), 72'd0);
          chk("stall_hold", win_now, exp_win(base, 0, 0));
          @(posedge clk);
          #1;
        end
        ready_in = 1'b1;
        valid_in = 1'b0;
      end
    end
    wait_done();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_window", win_now, 72'd0);
    chk("reset_ctrl", {69'd0, valid_out, ready_out, done}, 72'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_frame(0, 0);
    run_frame(20, 1);
`ifdef CONV33_WIN_STALL_CNT_EN
    chk("stall_cnt_after_done", 72'(stall_cnt), 72'd5);
`endif
    run_frame(40, 2);

    // Abort a frame after pixel 9, then check a fresh frame sees no stale data.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) push_pixel(8'(60 + i));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_window", win_now, 72'd0);
    chk("midreset_ctrl", {69'd0, valid_out, ready_out, done}, 72'd0);
    @(posedge clk);
    #1;
    run_frame(100, 0);

    run_frame(120, 3);
    run_frame(140, 0);
    run_frame(160, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
